// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADC serial-configuration engine.
package adc_cfg_pkg;

    localparam int unsigned WORD_W     = 24;
    localparam int unsigned BIT_W      = 5;
    localparam int unsigned N_INIT_TBL = 4;
    localparam int unsigned TBL_IW     = $clog2(N_INIT_TBL);

    typedef logic [WORD_W-1:0] word_t;

    // {addr[7:0], data[15:0]}; entry 0 is the soft reset
    localparam word_t INIT_TABLE [N_INIT_TBL] = '{
        24'h000001,
        24'h140001,
        24'h0D0000,
        24'hFF0001
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } sh_state_e;

    typedef enum logic [1:0] {
        CT_IDLE,
        CT_START,
        CT_RUN
    } ctl_state_e;

    // Bitwise 2-of-3 vote for the triplicated state and counters
    function automatic logic [7:0] maj3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// Serialises one 24-bit word MSB first with setup, hold and inter-word gap;
// a start in the last gap cycle chains the next word without idle time.
module adc_spi_shifter
    import adc_cfg_pkg::*;
#(
    parameter int unsigned N_ADC    = 12,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  word_t            word_i,
    input  logic [N_ADC-1:0] cs_b_i,
    output logic             done_c_o,
    output logic             sclk_o,
    output logic             sdata_o,
    output logic [N_ADC-1:0] cs_b_o
);

    localparam int unsigned      DIV_W     = $clog2(2 * SCLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_FROM = DIV_W'(SCLK_DIV);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

    sh_state_e        st_q  [3];
    logic [DIV_W-1:0] div_q [3];
    logic [BIT_W-1:0] bit_q [3];
    sh_state_e        st_v, st_d;
    logic [DIV_W-1:0] div_v, div_d;
    logic [BIT_W-1:0] bit_v, bit_d;
    word_t            shreg_q, shreg_d;
    logic [N_ADC-1:0] cs_pat_q, cs_pat_d;
    logic             sclk_q, sclk_d, sdata_q, sdata_d;
    logic [N_ADC-1:0] cs_b_q, cs_b_d;
    logic             active;

    assign st_v  = sh_state_e'(3'(maj3(8'(st_q[0]), 8'(st_q[1]), 8'(st_q[2]))));
    assign div_v = DIV_W'(maj3(8'(div_q[0]), 8'(div_q[1]), 8'(div_q[2])));
    assign bit_v = BIT_W'(maj3(8'(bit_q[0]), 8'(bit_q[1]), 8'(bit_q[2])));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= ST_IDLE;
                div_q[i] <= '0;
                bit_q[i] <= '0;
            end
            shreg_q  <= '0;
            cs_pat_q <= '1;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            cs_b_q   <= '1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= st_d;
                div_q[i] <= div_d;
                bit_q[i] <= bit_d;
            end
            shreg_q  <= shreg_d;
            cs_pat_q <= cs_pat_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            cs_b_q   <= cs_b_d;
        end
    end

    always_comb begin
        st_d     = st_v;
        div_d    = div_v + DIV_W'(1);
        bit_d    = bit_v;
        shreg_d  = shreg_q;
        cs_pat_d = cs_pat_q;
        done_c_o = 1'b0;
        case (st_v)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start_i) begin
                    st_d     = ST_SETUP;
                    shreg_d  = word_i;
                    cs_pat_d = cs_b_i;
                end
            end
            ST_SETUP: begin
                if (div_v == HALF_LAST) begin
                    st_d  = ST_SHIFT;
                    div_d = '0;
                end
            end
            ST_SHIFT: begin
                if (div_v == FULL_LAST) begin
                    div_d = '0;
                    if (bit_v == BIT_LAST) begin
                        st_d  = ST_HOLD;
                        bit_d = '0;
                    end else begin
                        bit_d   = bit_v + BIT_W'(1);
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (div_v == HALF_LAST) begin
                    st_d  = ST_GAP;
                    div_d = '0;
                end
            end
            ST_GAP: begin
                if (div_v == FULL_LAST) begin
                    done_c_o = 1'b1;
                    div_d    = '0;
                    bit_d    = '0;
                    if (start_i) begin
                        st_d     = ST_SETUP;
                        shreg_d  = word_i;
                        cs_pat_d = cs_b_i;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: begin
                st_d  = ST_IDLE;
                div_d = '0;
                bit_d = '0;
            end
        endcase
        // Pins are registered copies of the next-state view
        active  = (st_d == ST_SETUP) || (st_d == ST_SHIFT) || (st_d == ST_HOLD);
        cs_b_d  = active ? cs_pat_d : '1;
        sdata_d = active ? shreg_d[WORD_W-1] : 1'b0;
        sclk_d  = (st_d == ST_SHIFT) && (div_d >= HIGH_FROM);
    end

    assign sclk_o  = sclk_q;
    assign sdata_o = sdata_q;
    assign cs_b_o  = cs_b_q;

endmodule

// File: rtl/adc_cfg_sequencer.sv
// DCFEB ADC configuration engine: broadcasts the init table on an armed ADC_INIT
// and otherwise services single user register writes on the shared serial bus.
module adc_cfg_sequencer
    import adc_cfg_pkg::*;
#(
    parameter int unsigned N_ADC    = 12,
    parameter int unsigned SCLK_DIV = 4,
    parameter int unsigned N_INIT   = N_INIT_TBL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ADC_INIT,
    output logic             INIT_DONE,
    input  logic             USR_REQ,
    input  logic [7:0]       USR_ADDR,
    input  logic [15:0]      USR_DATA,
    input  logic [N_ADC-1:0] USR_CS_MASK,
    output logic             USR_ACK,
    output logic             BUSY,
    output logic             ADC_SCLK,
    output logic             ADC_SDATA,
    output logic [N_ADC-1:0] ADC_CS_B
);

    localparam int unsigned IDX_W = $clog2(N_INIT + 1);

    ctl_state_e       ct_q  [3];
    logic [IDX_W-1:0] idx_q [3];
    ctl_state_e       ct_v, ct_d;
    logic [IDX_W-1:0] idx_v, idx_d;
    logic             armed_q, armed_d, init_q, init_d;
    word_t            word_q, word_d, word_c;
    logic [N_ADC-1:0] mask_q, mask_d, cs_c;
    logic             done_q, done_d, ack_q, ack_d, busy_q, busy_d;
    logic             start_c, sh_done_c;

    assign ct_v  = ctl_state_e'(2'(maj3(8'(ct_q[0]), 8'(ct_q[1]), 8'(ct_q[2]))));
    assign idx_v = IDX_W'(maj3(8'(idx_q[0]), 8'(idx_q[1]), 8'(idx_q[2])));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                ct_q[i]  <= CT_IDLE;
                idx_q[i] <= '0;
            end
            armed_q <= 1'b1;
            init_q  <= 1'b0;
            word_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                ct_q[i]  <= ct_d;
                idx_q[i] <= idx_d;
            end
            armed_q <= armed_d;
            init_q  <= init_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        ct_d    = ct_v;
        idx_d   = idx_v;
        armed_d = armed_q | ~ADC_INIT;
        init_d  = init_q;
        word_d  = word_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        start_c = 1'b0;
        case (ct_v)
            CT_IDLE: begin
                // Init beats a simultaneous user request
                if (armed_q && ADC_INIT) begin
                    ct_d    = CT_START;
                    init_d  = 1'b1;
                    idx_d   = '0;
                    armed_d = 1'b0;
                end else if (USR_REQ) begin
                    ct_d   = CT_START;
                    init_d = 1'b0;
                    word_d = {USR_ADDR, USR_DATA};
                    mask_d = USR_CS_MASK;
                end
            end
            CT_START: begin
                if (!init_q && (mask_q == '0)) begin
                    ack_d = 1'b1;
                    ct_d  = CT_IDLE;
                end else begin
                    start_c = 1'b1;
                    ct_d    = CT_RUN;
                    if (init_q) idx_d = idx_v + IDX_W'(1);
                end
            end
            CT_RUN: begin
                if (sh_done_c) begin
                    if (init_q && (idx_v < IDX_W'(N_INIT))) begin
                        start_c = 1'b1;
                        idx_d   = idx_v + IDX_W'(1);
                    end else begin
                        ct_d   = CT_IDLE;
                        done_d = init_q;
                        ack_d  = ~init_q;
                    end
                end
            end
            default: ct_d = CT_IDLE;
        endcase
        busy_d = (ct_d == CT_RUN);
    end

    assign word_c = init_q ? INIT_TABLE[TBL_IW'(idx_v)] : word_q;
    assign cs_c   = init_q ? '0 : ~mask_q;

    adc_spi_shifter #(
        .N_ADC   (N_ADC),
        .SCLK_DIV(SCLK_DIV)
    ) u_shifter (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (start_c),
        .word_i  (word_c),
        .cs_b_i  (cs_c),
        .done_c_o(sh_done_c),
        .sclk_o  (ADC_SCLK),
        .sdata_o (ADC_SDATA),
        .cs_b_o  (ADC_CS_B)
    );

    assign INIT_DONE = done_q;
    assign USR_ACK   = ack_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Scoreboard bench: stimulus queues expected bus words and pulses, a bus monitor
// decodes the serial frames and checks them in order against the queue.
module tb_adc_cfg_sequencer;

    localparam int unsigned N_ADC    = 12;
    localparam int          WORD_CYC = 208;
    localparam int          INIT_CYC = 832;
    localparam int          K_WORD   = 0;
    localparam int          K_DONE   = 1;
    localparam int          K_ACK    = 2;

    typedef struct {
        int          kind;
        logic [23:0] word;
        logic [11:0] cs;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic             CLK = 1'b0;
    logic             RST;
    logic             ADC_INIT;
    logic             INIT_DONE;
    logic             USR_REQ;
    logic [7:0]       USR_ADDR;
    logic [15:0]      USR_DATA;
    logic [N_ADC-1:0] USR_CS_MASK;
    logic             USR_ACK;
    logic             BUSY;
    logic             ADC_SCLK;
    logic             ADC_SDATA;
    logic [N_ADC-1:0] ADC_CS_B;

    int cyc      = 0;
    int nchecks  = 0;
    int nerrors  = 0;
    logic [23:0] init_tab [4] = '{24'h000001, 24'h140001, 24'h0D0000, 24'hFF0001};

    adc_cfg_sequencer #(.N_ADC(N_ADC), .SCLK_DIV(4), .N_INIT(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADC_INIT   (ADC_INIT),
        .INIT_DONE  (INIT_DONE),
        .USR_REQ    (USR_REQ),
        .USR_ADDR   (USR_ADDR),
        .USR_DATA   (USR_DATA),
        .USR_CS_MASK(USR_CS_MASK),
        .USR_ACK    (USR_ACK),
        .BUSY       (BUSY),
        .ADC_SCLK   (ADC_SCLK),
        .ADC_SDATA  (ADC_SDATA),
        .ADC_CS_B   (ADC_CS_B)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void push(int kind, logic [23:0] w, logic [11:0] cs, int at);
        exp_q.push_back(exp_t'{kind, w, cs, at});
    endfunction

    function automatic void push_init(int c);
        for (int k = 0; k < 4; k++) push(K_WORD, init_tab[k], 12'h000, c + 2 + k * WORD_CYC);
        push(K_DONE, 24'h0, 12'h0, c + 2 + INIT_CYC);
    endfunction

    function automatic void observe(int kind, logic [23:0] w, logic [11:0] cs, int at, int nb,
                                    bit cs_bad);
        exp_t e;
        if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, at);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("event_cycle", 32'(at), 32'(e.cyc));
        if (kind == K_WORD && e.kind == K_WORD) begin
            chk("word_bits", 32'(w), 32'(e.word));
            chk("word_cs", 32'(cs), 32'(e.cs));
            chk("word_len", 32'(nb), 32'd24);
            chk("cs_stable", 32'(cs_bad), 32'd0);
        end
    endfunction

    // Bus monitor
    bit               in_frame = 1'b0;
    bit               cs_bad;
    logic             sclk_prev = 1'b0;
    logic [23:0]      fr_bits;
    int               fr_nb;
    int               fr_start;
    logic [N_ADC-1:0] fr_cs;

    always @(negedge CLK) begin
        if (RST) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && ADC_CS_B != '1) begin
                in_frame = 1'b1;
                cs_bad   = 1'b0;
                fr_bits  = '0;
                fr_nb    = 0;
                fr_start = cyc;
                fr_cs    = ADC_CS_B;
                chk("busy_at_cs", 32'(BUSY), 32'd1);
            end
            if (in_frame && ADC_CS_B != '1 && ADC_CS_B != fr_cs) cs_bad = 1'b1;
            if (in_frame && ADC_SCLK && !sclk_prev) begin
                fr_bits = {fr_bits[22:0], ADC_SDATA};
                fr_nb++;
            end
            if (in_frame && ADC_CS_B == '1) begin
                in_frame = 1'b0;
                observe(K_WORD, fr_bits, fr_cs, fr_start, fr_nb, cs_bad);
            end
            if (INIT_DONE) begin
                observe(K_DONE, 24'h0, 12'h0, cyc, 0, 1'b0);
                chk("busy_at_done", 32'(BUSY), 32'd0);
            end
            if (USR_ACK) begin
                observe(K_ACK, 24'h0, 12'h0, cyc, 0, 1'b0);
                chk("busy_at_ack", 32'(BUSY), 32'd0);
            end
        end
        sclk_prev = ADC_SCLK;
    end

    // Requester: hold USR_REQ until USR_ACK, optionally disturbing inputs once busy
    task automatic user_write(input logic [7:0] a, input logic [15:0] d, input logic [11:0] m,
                              input bit scramble, input int budget);
        bit got = 1'b0;
        bit done_scr = 1'b0;
        USR_ADDR    = a;
        USR_DATA    = d;
        USR_CS_MASK = m;
        USR_REQ     = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            if (scramble && BUSY && !done_scr) begin
                USR_ADDR    = ~a;
                USR_DATA    = ~d;
                USR_CS_MASK = ~m;
                done_scr    = 1'b1;
            end
            if (USR_ACK) got = 1'b1;
        end
        USR_REQ = 1'b0;
        if (!got) begin
            nchecks++;
            nerrors++;
            $display("FAIL ack_timeout: got no USR_ACK within %0d cycles, required one", budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        RST         = 1'b1;
        ADC_INIT    = 1'b0;
        USR_REQ     = 1'b0;
        USR_ADDR    = '0;
        USR_DATA    = '0;
        USR_CS_MASK = '0;
        repeat (3) @(negedge CLK);
        chk("rst_cs_b", 32'(ADC_CS_B), 32'hFFF);
        chk("rst_sclk", 32'(ADC_SCLK), 32'd0);
        chk("rst_sdata", 32'(ADC_SDATA), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_init_done", 32'(INIT_DONE), 32'd0);
        chk("rst_usr_ack", 32'(USR_ACK), 32'd0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Init run; ADC_INIT held high must not retrigger
        c = cyc;
        ADC_INIT = 1'b1;
        push_init(c);
        repeat (2000) @(negedge CLK);

        // Re-arm with a one-cycle low
        ADC_INIT = 1'b0;
        @(negedge CLK);
        ADC_INIT = 1'b1;
        c = cyc;
        push_init(c);
        repeat (900) @(negedge CLK);
        ADC_INIT = 1'b0;
        repeat (10) @(negedge CLK);

        // User write to CS 0 and 2, inputs disturbed mid-word
        c = cyc;
        push(K_WORD, 24'h42A5C3, 12'hFFA, c + 2);
        push(K_ACK, 24'h0, 12'h0, c + 2 + WORD_CYC);
        user_write(8'h42, 16'hA5C3, 12'h005, 1'b1, 400);
        repeat (10) @(negedge CLK);

        // Zero mask: immediate ack, no bus activity
        c = cyc;
        push(K_ACK, 24'h0, 12'h0, c + 2);
        user_write(8'h10, 16'h1234, 12'h000, 1'b0, 10);
        repeat (10) @(negedge CLK);

        // Contention: init first, user write accepted at the end of the INIT_DONE cycle
        c = cyc;
        ADC_INIT = 1'b1;
        push_init(c);
        push(K_WORD, 24'h3C0F0F, 12'h3FF, c + 2 + INIT_CYC + 2);
        push(K_ACK, 24'h0, 12'h0, c + 2 + INIT_CYC + 2 + WORD_CYC);
        user_write(8'h3C, 16'h0F0F, 12'hC00, 1'b0, 1500);
        ADC_INIT = 1'b0;
        repeat (10) @(negedge CLK);

        // Reset during bit 10 of a user word
        c = cyc;
        USR_ADDR    = 8'h11;
        USR_DATA    = 16'h2233;
        USR_CS_MASK = 12'h0F0;
        USR_REQ     = 1'b1;
        repeat (90) @(negedge CLK);
        chk("cs_mid_word", 32'(ADC_CS_B), 32'hF0F);
        chk("sclk_bit10_high", 32'(ADC_SCLK), 32'd1);
        RST     = 1'b1;
        USR_REQ = 1'b0;
        @(negedge CLK);
        chk("abort_cs_b", 32'(ADC_CS_B), 32'hFFF);
        chk("abort_sclk", 32'(ADC_SCLK), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(negedge CLK);

        // Recovery after the abort
        c = cyc;
        push(K_WORD, 24'h810180, 12'h7FF, c + 2);
        push(K_ACK, 24'h0, 12'h0, c + 2 + WORD_CYC);
        user_write(8'h81, 16'h0180, 12'h800, 1'b0, 400);
        repeat (20) @(negedge CLK);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
